dec_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the 3-to-8 decoder between eight requesters. Each cycle it owns the decoder's select and enable inputs, grants exactly one requester at a time, and holds the grant until the owner releases it, drops its request, or exceeds a hold limit. It sits directly in front of the decoder. Its registered `sel`/`en` pair feeds the decoder, and `gnt` is the registered one-hot equivalent for local use.

---
 rtl/dec_rr_scheduler.sv | 177 +++++++++++++++++
 tb/tb_dec_rr_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dec_rr_scheduler
// Purpose  : Round-robin owner scheduler placed in front of a 3-to-8 decoder.
//            It grants one of eight requesters at a time. The grant is held
//            until the owner releases it, drops its request, or reaches the
//            hold limit. One dead GAP cycle follows each grant before the next
//            IDLE arbitration.
// Ports    : clk    - clock, rising-edge active
//            rst_n  - asynchronous active-low reset
//            req[7:0] - request vector, bit i = requester i
//            rel    - owner release, honoured only while granting
//            sel[2:0] - registered owner index, drives decoder select
//            en     - registered decoder enable, high only while granting
//            gnt[7:0] - registered one-hot grant (1<<sel while en, else 0)
//            busy   - registered, high while granting or in the gap cycle
//            tmo    - registered one-cycle pulse when the hold limit ends a grant
// Params   : HOLD_MAX - maximum consecutive grant cycles, 0 = unlimited
// Revision : 1.0 - initial release
// ============================================================================
module dec_rr_scheduler #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [2:0] sel,
    output logic       en,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       tmo
);

    localparam int c_hcnt_w = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [c_hcnt_w-1:0] c_hold_sat  = c_hcnt_w'(HOLD_MAX);
    // hcnt is cleared on grant entry, so it reads HOLD_MAX-1 during the
    // HOLD_MAX-th grant cycle.
    localparam logic [c_hcnt_w-1:0] c_hold_last =
        (HOLD_MAX == 0) ? {c_hcnt_w{1'b0}} : c_hcnt_w'(HOLD_MAX - 1);
    localparam logic c_limit_on = (HOLD_MAX != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            ptr_q,   ptr_d;
    logic [c_hcnt_w-1:0]   hcnt_q,  hcnt_d;
    logic [2:0]            sel_q,   sel_d;
    logic                  en_q,    en_d;
    logic [7:0]            gnt_q,   gnt_d;
    logic                  busy_q,  busy_d;
    logic                  tmo_q,   tmo_d;

    // ------------------------------------------------------------------
    // Rotating-priority search. The loop runs from the largest offset down
    // to offset 0, so the last match written is the one closest to ptr.
    // ------------------------------------------------------------------
    logic       win_vld;
    logic [2:0] win_idx;

    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (req[3'(ptr_q + 3'(i))]) begin
                win_vld = 1'b1;
                win_idx = 3'(ptr_q + 3'(i));
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant termination causes, in priority order rel > drop > limit.
    // ------------------------------------------------------------------
    logic owner_req;
    logic limit_hit;
    logic grant_end;

    always_comb begin
        owner_req = req[sel_q];
        limit_hit = c_limit_on && (hcnt_q == c_hold_last);
        grant_end = rel || !owner_req || limit_hit;
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output computation
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        gnt_d   = gnt_q;
        tmo_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                en_d  = 1'b0;
                gnt_d = 8'h00;
                if (win_vld) begin
                    state_d = S_GRANT;
                    sel_d   = win_idx;
                    en_d    = 1'b1;
                    gnt_d   = 8'h01 << win_idx;
                    hcnt_d  = {c_hcnt_w{1'b0}};
                end
            end

            S_GRANT: begin
                if (hcnt_q != c_hold_sat) begin
                    hcnt_d = hcnt_q + c_hcnt_w'(1);
                end
                if (grant_end) begin
                    state_d = S_GAP;
                    ptr_d   = sel_q + 3'd1;
                    en_d    = 1'b0;
                    gnt_d   = 8'h00;
                    // Only the hold limit can be the cause once rel is low
                    // and the owner is still requesting.
                    tmo_d   = !rel && owner_req;
                end
            end

            S_GAP: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                gnt_d   = 8'h00;
            end

            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                gnt_d   = 8'h00;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 3'd0;
            hcnt_q  <= {c_hcnt_w{1'b0}};
            sel_q   <= 3'd0;
            en_q    <= 1'b0;
            gnt_q   <= 8'h00;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    assign sel  = sel_q;
    assign en   = en_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign tmo  = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_rr_scheduler
// Purpose  : Self-checking bench for dec_rr_scheduler. Two instances share
//            one stimulus, with HOLD_MAX=15 and HOLD_MAX=4. Each instance is
//            compared every cycle against a behavioural owner/queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_i = 8'h00;
    logic       rel_i = 1'b0;

    logic [2:0] sel15, sel4;
    logic       en15, en4, busy15, busy4, tmo15, tmo4;
    logic [7:0] gnt15, gnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dec_rr_scheduler #(.HOLD_MAX(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .req(req_i), .rel(rel_i),
        .sel(sel15), .en(en15), .gnt(gnt15), .busy(busy15), .tmo(tmo15)
    );

    dec_rr_scheduler #(.HOLD_MAX(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req_i), .rel(rel_i),
        .sel(sel4), .en(en4), .gnt(gnt4), .busy(busy4), .tmo(tmo4)
    );

    // Behavioural model: mode 0 = idle, 1 = owned, 2 = dead cycle.
    // held = number of cycles the current owner has had the decoder.
    typedef struct {
        int mode;
        int ptr;
        int sel;
        int held;
        int tmo;
    } mdl_t;

    mdl_t m15, m4;

    function automatic mdl_t mdl_step(mdl_t m, logic [7:0] r, logic rl, int h);
        mdl_t n = m;
        n.tmo = 0;
        if (m.mode == 0) begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (m.ptr + k) % 8;
                if (r[idx] && n.mode == 0) begin
                    n.mode = 1;
                    n.sel  = idx;
                    n.held = 1;
                end
            end
        end else if (m.mode == 1) begin
            if (rl || !r[m.sel] || (h != 0 && m.held >= h)) begin
                n.mode = 2;
                n.ptr  = (m.sel + 1) % 8;
                n.tmo  = (!rl && r[m.sel]) ? 1 : 0;
            end else begin
                n.held = m.held + 1;
            end
        end else begin
            n.mode = 0;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_one(input string tag, input mdl_t m, input logic [2:0] s,
                           input logic e, input logic [7:0] g, input logic b, input logic t);
        check({tag, ".sel"},  32'(s), m.sel);
        check({tag, ".en"},   32'(e), (m.mode == 1) ? 1 : 0);
        check({tag, ".gnt"},  32'(g), (m.mode == 1) ? (1 << m.sel) : 0);
        check({tag, ".busy"}, 32'(b), (m.mode != 0) ? 1 : 0);
        check({tag, ".tmo"},  32'(t), m.tmo);
    endtask

    task automatic tick(input logic [7:0] r, input logic rl);
        req_i = r;
        rel_i = rl;
        @(posedge clk);
        m15 = mdl_step(m15, r, rl, 15);
        m4  = mdl_step(m4,  r, rl, 4);
        #1;
        cmp_one("d15", m15, sel15, en15, gnt15, busy15, tmo15);
        cmp_one("d4",  m4,  sel4,  en4,  gnt4,  busy4,  tmo4);
    endtask

    // Reset is asserted between clock edges and checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.en15",   32'(en15),   0);
        check("rst.gnt15",  32'(gnt15),  0);
        check("rst.busy15", 32'(busy15), 0);
        check("rst.sel15",  32'(sel15),  0);
        check("rst.tmo15",  32'(tmo15),  0);
        check("rst.en4",    32'(en4),    0);
        check("rst.gnt4",   32'(gnt4),   0);
        check("rst.busy4",  32'(busy4),  0);
        m15 = '{default: 0};
        m4  = '{default: 0};
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] req;
        logic       rel;
        logic [2:0] sel;
        logic       en;
        logic [7:0] gnt;
        logic       busy;
        logic       tmo;
    } vec_t;

    vec_t tbl[21];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r;
        logic       rl;

        // Hold-limit and simultaneous-event vectors, checked against the
        // HOLD_MAX=4 instance starting from reset.
        tbl[0]  = '{8'h04, 1'b0, 3'd2, 1'b1, 8'h04, 1'b1, 1'b0};
        tbl[1]  = '{8'h04, 1'b0, 3'd2, 1'b1, 8'h04, 1'b1, 1'b0};
        tbl[2]  = '{8'h04, 1'b0, 3'd2, 1'b1, 8'h04, 1'b1, 1'b0};
        tbl[3]  = '{8'h04, 1'b0, 3'd2, 1'b1, 8'h04, 1'b1, 1'b0};
        tbl[4]  = '{8'h04, 1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5]  = '{8'h04, 1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{8'h04, 1'b0, 3'd2, 1'b1, 8'h04, 1'b1, 1'b0};
        tbl[7]  = '{8'h00, 1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{8'h00, 1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{8'h81, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0};
        tbl[10] = '{8'h81, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0};
        tbl[11] = '{8'h81, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0};
        tbl[12] = '{8'h81, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0};
        tbl[13] = '{8'h81, 1'b1, 3'd7, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[14] = '{8'h81, 1'b0, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[15] = '{8'h81, 1'b0, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[16] = '{8'h80, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[17] = '{8'h80, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[18] = '{8'h80, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0};
        tbl[19] = '{8'h00, 1'b0, 3'd7, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[20] = '{8'h00, 1'b0, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0};

        m15 = '{default: 0};
        m4  = '{default: 0};
        do_reset();

        // Rotation with every requester active; release in the first grant cycle.
        for (int k = 0; k < 9; k++) begin
            tick(8'hFF, 1'b0);
            check("rot.sel", 32'(sel15), k % 8);
            check("rot.gnt", 32'(gnt15), 1 << (k % 8));
            tick(8'hFF, 1'b1);
            check("rot.gap_en", 32'(en15), 0);
            tick(8'hFF, 1'b0);
            check("rot.idle_busy", 32'(busy15), 0);
        end

        // Wrap-around: requester 7 served, then 0 wins ahead of 7.
        tick(8'h80, 1'b0);
        check("wrap.sel7", 32'(sel15), 7);
        tick(8'h80, 1'b1);
        tick(8'h81, 1'b0);
        tick(8'h81, 1'b0);
        check("wrap.sel0", 32'(sel15), 0);
        tick(8'h81, 1'b1);
        tick(8'h81, 1'b0);
        tick(8'h81, 1'b0);
        check("wrap.sel7b", 32'(sel15), 7);
        tick(8'h81, 1'b1);
        tick(8'h00, 1'b0);

        // Asynchronous reset in the middle of a grant to requester 5.
        tick(8'h20, 1'b0);
        tick(8'h20, 1'b0);
        check("mid.sel5", 32'(sel15), 5);
        do_reset();
        tick(8'h20, 1'b0);
        check("post_rst.sel", 32'(sel15), 5);
        check("post_rst.en",  32'(en15), 1);
        tick(8'h20, 1'b1);
        tick(8'h00, 1'b0);

        // Table-driven hold-limit / simultaneous-event sequence.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            tick(tbl[i].req, tbl[i].rel);
            check($sformatf("tbl%0d.sel", i),  32'(sel4),  32'(tbl[i].sel));
            check($sformatf("tbl%0d.en", i),   32'(en4),   32'(tbl[i].en));
            check($sformatf("tbl%0d.gnt", i),  32'(gnt4),  32'(tbl[i].gnt));
            check($sformatf("tbl%0d.busy", i), 32'(busy4), 32'(tbl[i].busy));
            check($sformatf("tbl%0d.tmo", i),  32'(tmo4),  32'(tbl[i].tmo));
        end

        // Non-owner request toggling must not disturb owner 3.
        do_reset();
        tick(8'h48, 1'b0);
        check("nown.gnt0", 32'(gnt15), 8'h08);
        tick(8'hC8, 1'b0);
        check("nown.gnt1", 32'(gnt15), 8'h08);
        tick(8'h48, 1'b0);
        check("nown.gnt2", 32'(gnt15), 8'h08);
        tick(8'hC8, 1'b1);
        check("nown.rel_en", 32'(en15), 0);
        tick(8'hC8, 1'b0);
        tick(8'hC8, 1'b0);
        check("nown.sel6", 32'(sel15), 6);
        check("nown.gnt6", 32'(gnt15), 8'h40);
        tick(8'hC8, 1'b1);
        tick(8'h00, 1'b0);

        // Randomised traffic with sticky requests so hold limits are reached.
        r = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            r  = r ^ 8'($urandom & $urandom & $urandom);
            rl = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            tick(r, rl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
